interp_diag_sched: RTL and testbench

INTERP_DIAG_SCHED -- requirements
Module: interp_diag_sched

---
 rtl/interp_diag_sched.sv | 157 +++++++++++++++
 tb/tb_interp_diag_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_diag_sched.sv
// Scheduler for a shared diagonal interpolation unit. It issues four directions
// per sample set, collects the fixed-latency results and presents them as one set.
module interp_diag_sched #(
    parameter int LAT = 4,
    parameter int DW  = 8,
    parameter int RW  = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4*DW-1:0] q45_i,
    input  logic [4*DW-1:0] q135_i,
    input  logic [4*DW-1:0] q225_i,
    input  logic [4*DW-1:0] q315_i,
    input  logic            last_i,
    input  logic            flush_i,
    output logic            calc_valid_o,
    output logic [1:0]      calc_sel_o,
    output logic [DW-1:0]   calc_a_o,
    output logic [DW-1:0]   calc_b_o,
    output logic [DW-1:0]   calc_c_o,
    output logic [DW-1:0]   calc_d_o,
    input  logic [RW-1:0]   calc_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [RW-1:0]   s2_o,
    output logic [RW-1:0]   s4_o,
    output logic [RW-1:0]   s6_o,
    output logic [RW-1:0]   s8_o,
    output logic            done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [4*DW-1:0]   r_quad [4];
    logic [RW-1:0]     r_res [4];
    logic [3:0]        r_res_vld;
    logic [1:0]        r_cnt;
    logic              r_last;
    logic              r_done;
    logic [LAT-1:0]    r_tag_vld;
    logic [1:0]        r_tag_sel [LAT];

    logic              w_issue;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_tag_hit;
    logic [1:0]        w_tag_sel;
    logic [3:0]        w_res_vld_next;
    logic [4*DW-1:0]   w_issue_quad;

    assign w_issue   = (r_state == ISSUE);
    assign w_accept  = in_valid_i & in_ready_o & ~flush_i;
    assign w_out_hs  = out_valid_o & out_ready_i;
    assign w_tag_hit = r_tag_vld[LAT-1];
    assign w_tag_sel = r_tag_sel[LAT-1];

    // Ready is masked by reset so the handshake cannot be seen while held in reset.
    assign in_ready_o  = (r_state == IDLE) & rst_n;
    assign out_valid_o = (r_state == OUT);
    assign done_o      = r_done;
    assign s2_o        = r_res[0];
    assign s4_o        = r_res[1];
    assign s6_o        = r_res[2];
    assign s8_o        = r_res[3];

    always_comb begin
        w_res_vld_next = r_res_vld;
        if (w_tag_hit) begin
            w_res_vld_next[w_tag_sel] = 1'b1;
        end
    end

    always_comb begin
        w_issue_quad = r_quad[r_cnt];
        calc_valid_o = 1'b0;
        calc_sel_o   = 2'd0;
        calc_a_o     = '0;
        calc_b_o     = '0;
        calc_c_o     = '0;
        calc_d_o     = '0;
        if (w_issue) begin
            calc_valid_o = 1'b1;
            calc_sel_o   = r_cnt;
            calc_a_o     = w_issue_quad[4*DW-1:3*DW];
            calc_b_o     = w_issue_quad[3*DW-1:2*DW];
            calc_c_o     = w_issue_quad[2*DW-1:DW];
            calc_d_o     = w_issue_quad[DW-1:0];
        end
    end

    // The final result lands on the same edge that enters OUT, giving 4+LAT cycles.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:  if (w_accept) w_state_next = ISSUE;
            ISSUE: if (r_cnt == 2'd3) w_state_next = WAIT;
            WAIT:  if (w_res_vld_next == 4'hF) w_state_next = OUT;
            OUT:   if (out_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush_i) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_res_vld <= 4'd0;
            r_tag_vld <= '0;
            for (int k = 0; k < 4; k++) begin
                r_quad[k] <= '0;
                r_res[k]  <= '0;
            end
            for (int k = 0; k < LAT; k++) begin
                r_tag_sel[k] <= 2'd0;
            end
        end else begin
            r_state      <= w_state_next;
            r_done       <= w_out_hs & r_last & ~flush_i;
            r_tag_vld[0] <= w_issue & ~flush_i;
            r_tag_sel[0] <= r_cnt;
            for (int k = 1; k < LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1] & ~flush_i;
                r_tag_sel[k] <= r_tag_sel[k-1];
            end
            if (w_accept) begin
                r_quad[0] <= q45_i;
                r_quad[1] <= q135_i;
                r_quad[2] <= q225_i;
                r_quad[3] <= q315_i;
                r_last    <= last_i;
                r_cnt     <= 2'd0;
                r_res_vld <= 4'd0;
            end else if (flush_i) begin
                r_res_vld <= 4'd0;
            end else begin
                if (w_issue) begin
                    r_cnt <= r_cnt + 2'd1;
                end
                r_res_vld <= w_res_vld_next;
            end
            // A result coinciding with a flush belongs to the aborted set.
            if (w_tag_hit && !flush_i) begin
                r_res[w_tag_sel] <= calc_data_i;
            end
        end
    end

endmodule

// File: tb/tb_interp_diag_sched.sv
// Directed bench: three schedulers (LAT=4,1,8) each paired with a stub unit
// that returns the low RW bits of {A,B,C,D} exactly LAT cycles after issue.
module tb_interp_diag_sched;

    localparam int DW = 8;
    localparam int RW = 24;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] q45 = '0, q135 = '0, q225 = '0, q315 = '0;
    logic        last = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_valid   [ND];
    logic        in_ready   [ND];
    logic        calc_valid [ND];
    logic        out_valid  [ND];
    logic        done       [ND];
    logic [1:0]  calc_sel   [ND];
    logic [7:0]  ca [ND], cb [ND], cc [ND], cd [ND];
    logic [23:0] cdata [ND], s2 [ND], s4 [ND], s6 [ND], s8 [ND];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);
            logic [31:0] w_ops;
            logic [23:0] stub [L];
            assign w_ops = {ca[gi], cb[gi], cc[gi], cd[gi]};
            always @(posedge clk) begin
                stub[0] <= w_ops[23:0];
                for (int k = 1; k < L; k++) stub[k] <= stub[k-1];
            end
            assign cdata[gi] = stub[L-1];

            interp_diag_sched #(.LAT(L), .DW(DW), .RW(RW)) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .in_valid_i  (in_valid[gi]),
                .in_ready_o  (in_ready[gi]),
                .q45_i       (q45),
                .q135_i      (q135),
                .q225_i      (q225),
                .q315_i      (q315),
                .last_i      (last),
                .flush_i     (flush),
                .calc_valid_o(calc_valid[gi]),
                .calc_sel_o  (calc_sel[gi]),
                .calc_a_o    (ca[gi]),
                .calc_b_o    (cb[gi]),
                .calc_c_o    (cc[gi]),
                .calc_d_o    (cd[gi]),
                .calc_data_i (cdata[gi]),
                .out_valid_o (out_valid[gi]),
                .out_ready_i (out_ready),
                .s2_o        (s2[gi]),
                .s4_o        (s4[gi]),
                .s6_o        (s6[gi]),
                .s8_o        (s8[gi]),
                .done_o      (done[gi])
            );
        end
    endgenerate

    // Sample set k, direction dir: bytes {A,B,C,D}.
    function automatic logic [31:0] quad(input int k, input int dir);
        return 32'h01020304 + 32'(dir) * 32'h10101010 + 32'(k) * 32'h04040404;
    endfunction

    function automatic logic [23:0] res(input int k, input int dir);
        logic [31:0] q;
        q = quad(k, dir);
        return q[23:0];
    endfunction

    function automatic logic [23:0] sout(input int idx, input int dir);
        case (dir)
            0:       return s2[idx];
            1:       return s4[idx];
            2:       return s6[idx];
            default: return s8[idx];
        endcase
    endfunction

    // Presents set k and returns #1 after the accept edge (E0).
    task automatic send(input int idx, input int k, input logic lst, output bit ok);
        int n;
        n = 0;
        q45 = quad(k, 0); q135 = quad(k, 1); q225 = quad(k, 2); q315 = quad(k, 3);
        last = lst;
        in_valid[idx] = 1'b1;
        while (!in_ready[idx] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready[idx];
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
    endtask

    task automatic wait_out(input int idx, input int start, output int cyc, output int dn);
        cyc = start;
        dn  = 0;
        while (!out_valid[idx] && cyc < start + 40) begin
            @(posedge clk); #1; cyc++;
            dn += int'(done[idx]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if (in_ready[0] !== 0 || calc_valid[0] !== 0 || out_valid[0] !== 0 || done[0] !== 0 ||
            calc_sel[0] !== 0 || s2[0] !== 0 || s8[0] !== 0 || ca[0] !== 0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b cv=%b ov=%b done=%b sel=%0d s2=%h s8=%h a=%h required all 0",
                     in_ready[0], calc_valid[0], out_valid[0], done[0], calc_sel[0], s2[0], s8[0], ca[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) begin
            tests++;
            if (in_ready[i] !== 1) begin
                fails++; $display("FAIL reset_release_ready dut%0d: got %b required 1", i, in_ready[i]);
            end
        end
        idle(1);
    endtask

    task automatic test_single;
        bit ok; int cyc, dn; logic [31:0] q;
        logic [23:0] exp_s [4];
        exp_s = '{24'h020304, 24'h121314, 24'h222324, 24'h323334};
        out_ready = 1'b1;
        send(0, 0, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_accept: timeout waiting for ready"); end
        for (int j = 0; j < 4; j++) begin
            q = quad(0, j);
            tests++;
            if (calc_valid[0] !== 1 || calc_sel[0] !== 2'(j) || {ca[0], cb[0], cc[0], cd[0]} !== q) begin
                fails++;
                $display("FAIL single_issue%0d: valid=%b sel=%0d ops=%h required valid=1 sel=%0d ops=%h",
                         j, calc_valid[0], calc_sel[0], {ca[0], cb[0], cc[0], cd[0]}, j, q);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (calc_valid[0] !== 0 || calc_sel[0] !== 0 || {ca[0], cb[0], cc[0], cd[0]} !== 0) begin
            fails++;
            $display("FAIL single_issue_end: valid=%b sel=%0d ops=%h required all 0",
                     calc_valid[0], calc_sel[0], {ca[0], cb[0], cc[0], cd[0]});
        end
        wait_out(0, 4, cyc, dn);
        tests++;
        if (cyc !== 8) begin fails++; $display("FAIL single_latency: out_valid at E0+%0d required E0+8", cyc); end
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (sout(0, d) !== exp_s[d]) begin
                fails++; $display("FAIL single_result%0d: got %h required %h", d, sout(0, d), exp_s[d]);
            end
        end
        idle(1);
        tests++;
        if (out_valid[0] !== 0 || in_ready[0] !== 1 || done[0] !== 0) begin
            fails++;
            $display("FAIL single_after_hs: ov=%b rdy=%b done=%b required 0,1,0", out_valid[0], in_ready[0], done[0]);
        end
    endtask

    task automatic test_backpressure;
        bit ok; int cyc, dn;
        out_ready = 1'b0;
        send(0, 1, 1'b0, ok);
        wait_out(0, 0, cyc, dn);
        tests++;
        if (cyc !== 8) begin fails++; $display("FAIL bp_latency: out_valid at E0+%0d required E0+8", cyc); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid[0] !== 1 || in_ready[0] !== 0 || s2[0] !== res(1, 0) || s4[0] !== res(1, 1) ||
                s6[0] !== res(1, 2) || s8[0] !== res(1, 3)) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b rdy=%b s2=%h s8=%h required ov=1 rdy=0 s2=%h s8=%h",
                         i, out_valid[0], in_ready[0], s2[0], s8[0], res(1, 0), res(1, 3));
            end
            if (i == 0) begin
                q45 = quad(2, 0); q135 = quad(2, 1); q225 = quad(2, 2); q315 = quad(2, 3);
                in_valid[0] = 1'b1;
            end
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        tests++;
        if (out_valid[0] !== 0 || in_ready[0] !== 1) begin
            fails++; $display("FAIL bp_release: ov=%b rdy=%b required 0,1", out_valid[0], in_ready[0]);
        end
        send(0, 2, 1'b0, ok);
        wait_out(0, 0, cyc, dn);
        tests++;
        if (cyc !== 8) begin fails++; $display("FAIL bp_next_latency: got E0+%0d required E0+8", cyc); end
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (sout(0, d) !== res(2, d)) begin
                fails++; $display("FAIL bp_next_result%0d: got %h required %h", d, sout(0, d), res(2, d));
            end
        end
        idle(2);
    endtask

    task automatic test_done;
        bit ok; int cyc, dn, pulses;
        out_ready = 1'b1;
        send(0, 3, 1'b1, ok);
        wait_out(0, 0, cyc, dn);
        tests++;
        if (dn !== 0 || done[0] !== 0) begin fails++; $display("FAIL done_early: pulses=%0d required 0", dn); end
        idle(1);
        tests++;
        if (done[0] !== 1) begin fails++; $display("FAIL done_pulse: got %b required 1", done[0]); end
        idle(1);
        tests++;
        if (done[0] !== 0) begin fails++; $display("FAIL done_width: got %b required 0", done[0]); end
        send(0, 4, 1'b0, ok);
        wait_out(0, 0, cyc, dn);
        pulses = dn;
        repeat (5) begin idle(1); pulses += int'(done[0]); end
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL done_nolast: pulses=%0d required 0", pulses); end
    endtask

    task automatic test_flush;
        bit ok; int cyc, dn;
        out_ready = 1'b1;
        send(0, 5, 1'b1, ok);
        idle(5);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        tests++;
        if (out_valid[0] !== 0 || in_ready[0] !== 1 || done[0] !== 0) begin
            fails++;
            $display("FAIL flush_idle: ov=%b rdy=%b done=%b required 0,1,0", out_valid[0], in_ready[0], done[0]);
        end
        send(0, 6, 1'b0, ok);
        wait_out(0, 0, cyc, dn);
        tests++;
        if (cyc !== 8 || dn !== 0) begin
            fails++; $display("FAIL flush_next_timing: out_valid at E0+%0d done=%0d required E0+8 and 0", cyc, dn);
        end
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (sout(0, d) !== res(6, d)) begin
                fails++; $display("FAIL flush_next_result%0d: got %h required %h", d, sout(0, d), res(6, d));
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        bit ok; int cyc, dn, bad;
        out_ready = 1'b1;
        send(0, 7, 1'b1, ok);
        idle(1);
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready[0] !== 0 || calc_valid[0] !== 0 || calc_sel[0] !== 0 || {ca[0], cb[0], cc[0], cd[0]} !== 0 ||
            out_valid[0] !== 0 || done[0] !== 0 || s2[0] !== 0 || s4[0] !== 0 || s6[0] !== 0 || s8[0] !== 0) begin
            fails++;
            $display("FAIL rstmid_outputs: rdy=%b cv=%b sel=%0d ops=%h ov=%b done=%b s2=%h required all 0",
                     in_ready[0], calc_valid[0], calc_sel[0], {ca[0], cb[0], cc[0], cd[0]}, out_valid[0], done[0], s2[0]);
        end
        idle(2);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready[0] !== 1) begin fails++; $display("FAIL rstmid_ready: got %b required 1", in_ready[0]); end
        bad = 0;
        repeat (10) begin idle(1); bad += int'(done[0]) + int'(out_valid[0]); end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL rstmid_quiet: done/out_valid cycles=%0d required 0", bad); end
        send(0, 8, 1'b0, ok);
        wait_out(0, 0, cyc, dn);
        tests++;
        if (cyc !== 8) begin fails++; $display("FAIL rstmid_latency: got E0+%0d required E0+8", cyc); end
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (sout(0, d) !== res(8, d)) begin
                fails++; $display("FAIL rstmid_result%0d: got %h required %h", d, sout(0, d), res(8, d));
            end
        end
        idle(2);
    endtask

    task automatic test_lat_sweep;
        bit ok; int cyc, dn, want;
        out_ready = 1'b1;
        for (int idx = 1; idx < ND; idx++) begin
            want = (idx == 1) ? 5 : 12;
            send(idx, 9, 1'b0, ok);
            wait_out(idx, 0, cyc, dn);
            tests++;
            if (cyc !== want) begin
                fails++; $display("FAIL sweep_latency dut%0d: out_valid at E0+%0d required E0+%0d", idx, cyc, want);
            end
            for (int d = 0; d < 4; d++) begin
                tests++;
                if (sout(idx, d) !== res(9, d)) begin
                    fails++; $display("FAIL sweep_result dut%0d dir%0d: got %h required %h", idx, d, sout(idx, d), res(9, d));
                end
            end
            idle(2);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int idx = 1; idx < ND; idx++) begin
            fork
                begin : producer
                    bit ok;
                    for (int j = 0; j < 4; j++) begin
                        send(idx, 10 + j, 1'b0, ok);
                        tests++;
                        if (!ok) begin fails++; $display("FAIL b2b_accept dut%0d set%0d: timeout", idx, j); end
                    end
                end
                begin : consumer
                    int got, n;
                    got = 0;
                    n = 0;
                    while (got < 4 && n < 300) begin
                        idle(1); n++;
                        if (out_valid[idx]) begin
                            for (int d = 0; d < 4; d++) begin
                                tests++;
                                if (sout(idx, d) !== res(10 + got, d)) begin
                                    fails++;
                                    $display("FAIL b2b_result dut%0d set%0d dir%0d: got %h required %h",
                                             idx, got, d, sout(idx, d), res(10 + got, d));
                                end
                            end
                            got++;
                        end
                    end
                    tests++;
                    if (got !== 4) begin fails++; $display("FAIL b2b_count dut%0d: got %0d sets required 4", idx, got); end
                end
            join
            idle(2);
        end
    endtask

    initial begin
        for (int i = 0; i < ND; i++) in_valid[i] = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_done();
        test_flush();
        test_reset_mid();
        test_lat_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
